// File: rtl/uvme_cvmcu_io_router_pkg.sv
// Shared types for the bench I/O router: FSM state, route-table entry and
// reject cause, plus the saturating increment used by the optional counters.
package uvme_cvmcu_io_router_pkg;

    // Pad fields in a route entry are wide enough for up to 256 pads.
    localparam int ROUTE_PAD_W = 8;
    localparam int STAT_W      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic                   en;
        logic [ROUTE_PAD_W-1:0] tx_pad;
        logic [ROUTE_PAD_W-1:0] rx_pad;
    } route_t;

    typedef enum logic [1:0] {
        REJ_NONE        = 2'd0,
        REJ_PAD_RANGE   = 2'd1,
        REJ_TX_CONFLICT = 2'd2
    } reject_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uvme_cvmcu_io_router_if.sv
// Route-change request/status bundle of the bench I/O router.
// The master side issues requests, the slave side (the router) answers.
interface uvme_cvmcu_io_router_if #(
    parameter int NUM_PADS = 48,
    parameter int NUM_CH   = 8
);
    localparam int CH_W  = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1;
    localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CH_W-1:0]  cfg_ch_i;
    logic             cfg_en_i;
    logic [PAD_W-1:0] cfg_tx_pad_i;
    logic [PAD_W-1:0] cfg_rx_pad_i;
    logic             busy_o;
    logic             err_o;

    modport master (
        output cfg_valid_i, cfg_ch_i, cfg_en_i, cfg_tx_pad_i, cfg_rx_pad_i,
        input  cfg_ready_o, busy_o, err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_ch_i, cfg_en_i, cfg_tx_pad_i, cfg_rx_pad_i,
        output cfg_ready_o, busy_o, err_o
    );

endinterface

// File: rtl/uvme_cvmcu_io_router_table.sv
// Route table of the bench I/O router: one entry per channel, written only
// by an accepted commit, plus the combinational validity check of a
// candidate entry against the current table.
module uvme_cvmcu_io_router_table
    import uvme_cvmcu_io_router_pkg::*;
#(
    parameter int  NUM_PADS = 48,
    parameter int  NUM_CH   = 8,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_wr,
    input  logic [CH_W-1:0] i_ch,
    input  route_t          i_entry,
    output route_t          o_tab [NUM_CH],
    output reject_e         o_cause
);

    route_t r_tab [NUM_CH];

    // Table storage: cleared by reset, one entry rewritten per commit.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_tab[c] <= '0;
            end
        end else if (i_wr && (int'(i_ch) < NUM_CH)) begin
            r_tab[i_ch] <= i_entry;
        end
    end

    // Candidate check: pads must exist and the tx pad must not be driven by
    // any other enabled channel (the channel's own old entry never conflicts).
    always_comb begin
        o_cause = REJ_NONE;
        if ((int'(i_entry.tx_pad) >= NUM_PADS) || (int'(i_entry.rx_pad) >= NUM_PADS)) begin
            o_cause = REJ_PAD_RANGE;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ((CH_W'(c) != i_ch) && r_tab[c].en && (r_tab[c].tx_pad == i_entry.tx_pad)) begin
                    o_cause = REJ_TX_CONFLICT;
                end
            end
        end
    end

    assign o_tab = r_tab;

endmodule

// File: rtl/uvme_cvmcu_io_router.sv
// Bench I/O router: connects single-bit serial channels to chip pads.
// A route change is quiesced for SETTLE_CYC cycles, then validated and
// committed in one cycle. Pad and channel outputs are registered.
// Optional feature: define UVME_CVMCU_IO_ROUTER_STATS_EN to add per-channel
// 16-bit saturating rx-edge counters (stat_ch_i / stat_clr_i / stat_cnt_o).
module uvme_cvmcu_io_router
    import uvme_cvmcu_io_router_pkg::*;
#(
    parameter int   NUM_PADS   = 48,
    parameter int   NUM_CH     = 8,
    parameter int   SETTLE_CYC = 4,
    parameter logic IDLE_LVL   = 1'b1,
    localparam int  CH_W       = (NUM_CH   > 1) ? $clog2(NUM_CH)   : 1,
    localparam int  PAD_W      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                ref_clk_i,
    input  logic                rstn_i,
    uvme_cvmcu_io_router_if.slave cfg,
    input  logic [NUM_CH-1:0]   ch_tx_i,
    output logic [NUM_CH-1:0]   ch_rx_o,
    input  logic [NUM_PADS-1:0] io_out_i,
    input  logic [NUM_PADS-1:0] io_oe_i,
    output logic [NUM_PADS-1:0] io_in_o
`ifdef UVME_CVMCU_IO_ROUTER_STATS_EN
    ,
    input  logic [CH_W-1:0]     stat_ch_i,
    input  logic                stat_clr_i,
    output logic [STAT_W-1:0]   stat_cnt_o
`endif
);

    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYC - 1);

    state_e             r_state;
    logic [7:0]         r_cnt;
    logic [CH_W-1:0]    r_req_ch;
    logic               r_req_en;
    logic [PAD_W-1:0]   r_req_tx;
    logic [PAD_W-1:0]   r_req_rx;
    logic               r_ready;
    logic               r_busy;
    logic               r_err;

    logic               w_accept;
    logic               w_reject;
    logic               w_wr;
    route_t             w_new;
    route_t             w_tab [NUM_CH];
    reject_e            w_cause;
    logic [NUM_CH-1:0]  w_hold;
    logic [NUM_PADS-1:0] w_io_in_nxt;
    logic [NUM_CH-1:0]  w_rx_nxt;
    logic [NUM_PADS-1:0] r_io_in;
    logic [NUM_CH-1:0]  r_rx;

    // r_ready is only ever high in IDLE, so this is the acceptance strobe.
    assign w_accept = cfg.cfg_valid_i & r_ready;
    // Disconnects are never rejected.
    assign w_reject = r_req_en && (w_cause != REJ_NONE);
    assign w_wr     = (r_state == COMMIT) && !w_reject;

    // Candidate entry built from the latched request; pads are dropped on disconnect.
    always_comb begin
        w_new    = '0;
        w_new.en = r_req_en;
        if (r_req_en) begin
            w_new.tx_pad = ROUTE_PAD_W'(r_req_tx);
            w_new.rx_pad = ROUTE_PAD_W'(r_req_rx);
        end
    end

    uvme_cvmcu_io_router_table #(
        .NUM_PADS (NUM_PADS),
        .NUM_CH   (NUM_CH)
    ) u_table (
        .i_clk    (ref_clk_i),
        .i_rstn   (rstn_i),
        .i_wr     (w_wr),
        .i_ch     (r_req_ch),
        .i_entry  (w_new),
        .o_tab    (w_tab),
        .o_cause  (w_cause)
    );

    // Route-change FSM with registered handshake and status outputs.
    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_req_ch <= '0;
            r_req_en <= 1'b0;
            r_req_tx <= '0;
            r_req_rx <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= QUIESCE;
                        r_cnt    <= SETTLE_M1;
                        r_req_ch <= cfg.cfg_ch_i;
                        r_req_en <= cfg.cfg_en_i;
                        r_req_tx <= cfg.cfg_tx_pad_i;
                        r_req_rx <= cfg.cfg_rx_pad_i;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                QUIESCE: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= COMMIT;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                COMMIT: begin
                    r_err   <= w_reject;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // The target channel is held idle on both sides while its route changes.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_hold[c] = (r_state != IDLE) && (r_req_ch == CH_W'(c));
        end
    end

    // Next pad-input and channel-rx values from the current table.
    always_comb begin
        w_io_in_nxt = {NUM_PADS{IDLE_LVL}};
        w_rx_nxt    = {NUM_CH{IDLE_LVL}};
        for (int p = 0; p < NUM_PADS; p++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_tab[c].en && !w_hold[c]) begin
                    if (w_tab[c].tx_pad == ROUTE_PAD_W'(p)) begin
                        w_io_in_nxt[p] = ch_tx_i[c];
                    end
                    if ((w_tab[c].rx_pad == ROUTE_PAD_W'(p)) && io_oe_i[p]) begin
                        w_rx_nxt[c] = io_out_i[p];
                    end
                end
            end
        end
    end

    // Output registers of the datapath (latency 1).
    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_io_in <= {NUM_PADS{IDLE_LVL}};
            r_rx    <= {NUM_CH{IDLE_LVL}};
        end else begin
            r_io_in <= w_io_in_nxt;
            r_rx    <= w_rx_nxt;
        end
    end

`ifdef UVME_CVMCU_IO_ROUTER_STATS_EN
    logic [STAT_W-1:0] r_stat [NUM_CH];

    // Count every level change seen on each registered rx line; clear wins.
    always_ff @(posedge ref_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_stat[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (stat_clr_i) begin
                    r_stat[c] <= '0;
                end else if (w_rx_nxt[c] != r_rx[c]) begin
                    r_stat[c] <= sat_inc(r_stat[c]);
                end
            end
        end
    end

    assign stat_cnt_o = r_stat[stat_ch_i];
`endif

    assign io_in_o         = r_io_in;
    assign ch_rx_o         = r_rx;
    assign cfg.cfg_ready_o = r_ready;
    assign cfg.busy_o      = r_busy;
    assign cfg.err_o       = r_err;

endmodule

// File: doc/uvme_cvmcu_io_router.md
UVME_CVMCU_IO_ROUTER -- requirements
Module: uvme_cvmcu_io_router

Interface
REQ-001 SHALL have parameter NUM_PADS, default 48: number of chip pads routed.
REQ-002 SHALL have parameter NUM_CH, default 8: number of bench serial channels (UART/SPI-style single-bit tx/rx pairs).
REQ-003 SHALL have parameter SETTLE_CYC, default 4: quiesce cycles before a route change commits; legal range 1..255.
REQ-004 SHALL have parameter IDLE_LVL, default 1'b1: level driven on unrouted rx lines and unowned pads.
REQ-005 SHALL have port ref_clk_i, input, 1 bit: sole clock; reset is asynchronous and active-low, port rstn_i.
REQ-006 SHALL have port rstn_i, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port cfg_valid_i, input, 1 bit: route-change request valid.
REQ-008 SHALL have port cfg_ready_o, output, 1 bit: router accepts a request.
REQ-009 SHALL have port cfg_ch_i, input, $clog2(NUM_CH) bits: target channel.
REQ-010 SHALL have port cfg_en_i, input, 1 bit: 1 connects the channel, 0 disconnects it.
REQ-011 SHALL have ports cfg_tx_pad_i and cfg_rx_pad_i, input, $clog2(NUM_PADS) bits each: pad indices.
REQ-012 SHALL have port ch_tx_i, input, NUM_CH bits: channel transmit lines.
REQ-013 SHALL have port ch_rx_o, output, NUM_CH bits: channel receive lines.
REQ-014 SHALL have ports io_out_i and io_oe_i, input, NUM_PADS bits each: DUT pad output and output enable.
REQ-015 SHALL have port io_in_o, output, NUM_PADS bits: DUT pad input.
REQ-016 SHALL have port busy_o, output, 1 bit: route change in progress.
REQ-017 SHALL have port err_o, output, 1 bit: one-cycle pulse on a rejected request.

Function
REQ-018 Datapath SHALL be registered with latency 1: io_in_o[p] = ch_tx_i[c] if enabled channel c owns tx pad p, else IDLE_LVL.
REQ-019 ch_rx_o[c] SHALL be io_out_i[rx_pad] when c is enabled and io_oe_i[rx_pad]=1, else IDLE_LVL, with latency 1.
REQ-020 FSM states SHALL be IDLE, QUIESCE and COMMIT; cfg_ready_o=1 only in IDLE; a request is accepted on cfg_valid_i&cfg_ready_o.
REQ-021 On acceptance the FSM SHALL enter QUIESCE, where the target channel's rx and old tx pad are held at IDLE_LVL for SETTLE_CYC cycles; other channels are unaffected.
REQ-022 COMMIT SHALL last one cycle, validate the request, update the route table, and return to IDLE; busy_o=1 in QUIESCE and COMMIT.
REQ-023 A request SHALL be rejected in COMMIT (err_o pulse, table unchanged, channel restored to its prior route) if a pad index >= NUM_PADS or the tx pad is owned by another enabled channel.
REQ-024 rx pads MAY be shared by several channels; a channel's tx pad equal to its own rx pad SHALL be legal.
REQ-025 A disconnect request (cfg_en_i=0) SHALL ignore the pad fields and never be rejected.

Reset
REQ-026 On rstn_i low SHALL: FSM=IDLE, all channels disabled, io_in_o=all IDLE_LVL, ch_rx_o=all IDLE_LVL, cfg_ready_o=0 while asserted then 1 on the first cycle after release, busy_o=0, err_o=0.
REQ-027 Reset asserted in QUIESCE/COMMIT SHALL abort the change with no table update.

Configuration
REQ-028 Macro UVME_CVMCU_IO_ROUTER_STATS_EN SHALL add per-channel 16-bit saturating rx-edge counters, selected by input stat_ch_i and output stat_cnt_o and cleared by input stat_clr_i; without the macro these ports and counters SHALL not exist.

Structure
REQ-029 Package uvme_cvmcu_io_router_pkg SHALL hold the FSM state enum, the route-entry struct (en, tx_pad, rx_pad) and the reject-cause enum.
REQ-030 Sub-module uvme_cvmcu_io_router_table SHALL hold the route table and the conflict check; FSM and datapath SHALL stay in the top.

Verification
REQ-031 Reset release -> io_in_o=48'hFFFF_FFFF_FFFF, ch_rx_o=8'hFF, cfg_ready_o=1.
REQ-032 Route ch0 tx=7 rx=8, SETTLE_CYC=4 -> busy_o high 5 cycles; then ch_tx_i[0] toggle appears on io_in_o[7] one cycle later.
REQ-033 Route ch1 tx=7 while ch0 owns 7 -> err_o one-cycle pulse, ch1 remains disabled, io_in_o[7] still follows ch0.
REQ-034 io_oe_i[8]=0 with ch0 rx=8 -> ch_rx_o[0]=1 regardless of io_out_i[8].
REQ-035 Reset asserted at QUIESCE cycle 2 -> all outputs at reset values and table empty.
REQ-036 With STATS_EN, 10 rx edges on ch0 -> stat_cnt_o=10; after 70000 edges -> 16'hFFFF.
